// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// The illegal flag exists only when IMMGEN_ILLEGAL_EN is defined.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_code;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  logic [2:0]      imm_fmt;
`ifdef IMMGEN_ILLEGAL_EN
  logic            illegal;

  // Producer of instructions / consumer of immediates
  modport master (
    output in_valid, inst_code, out_ready,
    input  in_ready, out_valid, imm_out, imm_fmt, illegal
  );

  // The immediate generator itself
  modport slave (
    input  in_valid, inst_code, out_ready,
    output in_ready, out_valid, imm_out, imm_fmt, illegal
  );
`else
  // Producer of instructions / consumer of immediates
  modport master (
    output in_valid, inst_code, out_ready,
    input  in_ready, out_valid, imm_out, imm_fmt
  );

  // The immediate generator itself
  modport slave (
    input  in_valid, inst_code, out_ready,
    output in_ready, out_valid, imm_out, imm_fmt
  );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry skid buffer.
// Optional feature macro: IMMGEN_ILLEGAL_EN adds a registered illegal flag per entry.
// Instructions are decoded before storage; main entry drives outputs, skid holds one more.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  imm_gen_pipe_if.slave   bus
);

  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd5;
  localparam logic [FMT_W-1:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Buffer occupancy states
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_bad
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [31:0]      inst;
  logic [6:0]       opcode;
  logic [XLEN-1:0]  dec_imm;
  logic [FMT_W-1:0] dec_fmt;

  logic [1:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, pop;
  logic             main_ld_dec, main_ld_skid, skid_ld, clr;

  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [FMT_W-1:0] main_fmt, skid_fmt;

  assign inst   = bus.inst_code;
  assign opcode = inst[6:0];

  // Combinational immediate decode of the incoming instruction
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_imm = XLEN'($signed(inst[31:20]));
        dec_fmt = FMT_I;
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          dec_imm = XLEN'($signed(inst[31:20]));
          dec_fmt = FMT_I;
        end
      end
      OP_STORE: begin
        dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        dec_fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm = XLEN'($signed({inst[31:12], 12'b0}));
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        dec_fmt = FMT_J;
      end
      OP_SYSTEM: begin
        if (inst[14]) begin
          dec_imm = XLEN'(inst[19:15]);
          dec_fmt = FMT_Z;
        end
      end
      default: begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
  end

`ifdef IMMGEN_ILLEGAL_EN
  logic dec_ill;
  logic main_ill, skid_ill;

  // Illegal: non-32-bit encoding, or no immediate format except the CSR register forms
  always_comb begin
    dec_ill = (inst[1:0] != 2'b11) ||
              ((dec_fmt == FMT_NONE) && !((opcode == OP_SYSTEM) && !inst[14]));
  end
`endif

  assign accept = bus.in_valid && in_ready_q && !flush;
  assign pop    = out_valid_q && bus.out_ready;

  // Occupancy FSM state and handshake flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next occupancy and buffer load controls
  always_comb begin
    state_d      = state_q;
    main_ld_dec  = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    clr          = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
      clr     = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_ld_dec = 1'b1;
            state_d     = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_ld_dec = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = S_TWO;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            main_ld_skid = 1'b1;
            state_d      = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_TWO);
  end

  // Main and skid entry storage
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      main_imm <= '0;
      main_fmt <= FMT_NONE;
      skid_imm <= '0;
      skid_fmt <= FMT_NONE;
    end else begin
      if (main_ld_dec) begin
        main_imm <= dec_imm;
        main_fmt <= dec_fmt;
      end else if (main_ld_skid) begin
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
      end
      if (skid_ld) begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
      end
    end
  end

`ifdef IMMGEN_ILLEGAL_EN
  // Illegal flag travels with its entry
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      main_ill <= 1'b0;
      skid_ill <= 1'b0;
    end else begin
      if (main_ld_dec) begin
        main_ill <= dec_ill;
      end else if (main_ld_skid) begin
        main_ill <= skid_ill;
      end
      if (skid_ld) begin
        skid_ill <= dec_ill;
      end
    end
  end

  assign bus.illegal = main_ill;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm_out   = main_imm;
  assign bus.imm_fmt   = main_fmt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed + randomized check of imm_gen_pipe against a queue-based model.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;

  imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

  imm_gen_pipe #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   failures;
  exp_t mq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xl(input logic [63:0] v);
    return (XLEN == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  // Reference decode using 64-bit signed arithmetic on the raw word
  function automatic exp_t ref_decode(input logic [31:0] ic);
    exp_t   e;
    longint sx;
    longint v;
    logic [2:0] f;
    sx = longint'($signed(ic));
    v  = 0;
    f  = 3'd0;
    case (ic[6:0])
      7'h03, 7'h13, 7'h67: begin v = sx >>> 20; f = 3'd1; end
      7'h1B: if (XLEN == 64) begin v = sx >>> 20; f = 3'd1; end
      7'h23: begin v = ((sx >>> 25) << 5) | longint'(ic[11:7]); f = 3'd2; end
      7'h63: begin
        v = ((sx >>> 31) << 12) | (longint'(ic[7]) << 11) |
            (longint'(ic[30:25]) << 5) | (longint'(ic[11:8]) << 1);
        f = 3'd3;
      end
      7'h37, 7'h17: begin v = (sx >>> 12) << 12; f = 3'd4; end
      7'h6F: begin
        v = ((sx >>> 31) << 20) | (longint'(ic[19:12]) << 12) |
            (longint'(ic[20]) << 11) | (longint'(ic[30:21]) << 1);
        f = 3'd5;
      end
      7'h73: if (ic[14]) begin v = longint'(ic[19:15]); f = 3'd6; end
      default: begin v = 0; f = 3'd0; end
    endcase
    e.imm = xl(64'(v));
    e.fmt = f;
    e.ill = (ic[1:0] != 2'b11) || ((f == 3'd0) && !((ic[6:0] == 7'h73) && !ic[14]));
    return e;
  endfunction

  // Compare all DUT outputs against the model queue head
  task automatic check_outs();
    check("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    check("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      check("imm_out", 64'(bus.imm_out), mq[0].imm);
      check("imm_fmt", 64'(bus.imm_fmt), 64'(mq[0].fmt));
`ifdef IMMGEN_ILLEGAL_EN
      check("illegal", 64'(bus.illegal), 64'(mq[0].ill));
`endif
    end
  endtask

  // One clock: check, drive, advance the model, then wait to the next falling edge
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [31:0] ic, input logic ordy, output logic acc);
    logic m_ovalid;
    logic m_iready;
    check_outs();
    reset         = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.inst_code = ic;
    bus.out_ready = ordy;
    m_ovalid = (mq.size() > 0);
    m_iready = (mq.size() < 2);
    acc = 1'b0;
    if (r || f) begin
      mq.delete();
    end else begin
      if (m_ovalid && ordy) void'(mq.pop_front());
      if (iv && m_iready) begin
        mq.push_back(ref_decode(ic));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, ordy, a);
  endtask

  task automatic push(input logic [31:0] ic, input logic ordy);
    logic a;
    cycle(1'b0, 1'b0, 1'b1, ic, ordy, a);
  endtask

  task automatic head(input string tag, input logic [63:0] imm, input logic [2:0] fmt);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_imm"}, 64'(bus.imm_out), imm);
    check({tag, "_fmt"}, 64'(bus.imm_fmt), 64'(fmt));
  endtask

  task automatic directed(input string tag, input logic [31:0] ic,
                          input logic [63:0] imm, input logic [2:0] fmt);
    push(ic, 1'b1);
    head(tag, imm, fmt);
    idle(1'b1);
  endtask

  logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
  logic [31:0] pend;
  logic        have_pend;
  logic        acc;

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = ops[$urandom_range(11)];
    if ($urandom_range(9) == 0) w[1:0] = 2'($urandom_range(2));
    return w;
  endfunction

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.inst_code = 32'h0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle(1'b0);

    // Post-reset values
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_imm", 64'(bus.imm_out), 64'd0);
    check("rst_fmt", 64'(bus.imm_fmt), 64'd0);

    // Reference instructions
    directed("addi", 32'hFFF00093, xl(64'hFFFF_FFFF_FFFF_FFFF), 3'd1);
    directed("lui", 32'h123450B7, 64'h1234_5000, 3'd4);
    directed("beq", 32'hFE000EE3, xl(64'hFFFF_FFFF_FFFF_FFFC), 3'd3);
    directed("jal", 32'h001000EF, 64'h800, 3'd5);
    directed("csrrwi", 32'h305FD073, 64'h1F, 3'd6);
    push(32'h0000_0000, 1'b1);
    head("zero", 64'h0, 3'd0);
`ifdef IMMGEN_ILLEGAL_EN
    check("zero_illegal", 64'(bus.illegal), 64'd1);
`endif
    idle(1'b1);

    // Backpressure: third instruction waits for space, order preserved
    push(32'hFFF00093, 1'b0);
    push(32'h123450B7, 1'b0);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    push(32'h001000EF, 1'b0);
    check("still_full", 64'(bus.in_ready), 64'd0);
    head("bp_first", xl(64'hFFFF_FFFF_FFFF_FFFF), 3'd1);
    push(32'h001000EF, 1'b1);
    check("ready_after_pop", 64'(bus.in_ready), 64'd1);
    head("bp_second", 64'h1234_5000, 3'd4);
    push(32'h001000EF, 1'b1);
    head("bp_third", 64'h800, 3'd5);
    idle(1'b1);

    // Flush while full, with an input presented in the flush cycle
    push(32'hFFF00093, 1'b0);
    push(32'h123450B7, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h001000EF, 1'b0, acc);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    check("flush_dropped", 64'(bus.out_valid), 64'd0);

    // Reset with one entry held
    push(32'hFE000EE3, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_imm", 64'(bus.imm_out), 64'd0);
    check("mid_rst_fmt", 64'(bus.imm_fmt), 64'd0);

    // Randomized traffic; an offered instruction is held until accepted
    have_pend = 1'b0;
    pend      = 32'h0;
    for (int i = 0; i < 800; i++) begin
      logic iv;
      logic r;
      logic f;
      if (!have_pend) begin
        pend      = rand_inst();
        have_pend = ($urandom_range(9) < 7);
      end
      iv = have_pend;
      r  = ($urandom_range(99) == 0);
      f  = ($urandom_range(29) == 0);
      cycle(r, f, iv, pend, 1'($urandom_range(9) < 6), acc);
      if (acc || r || f) have_pend = 1'b0;
    end
    idle(1'b1);
    idle(1'b1);
    check_outs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
